// File: rtl/imm_ext_pipe.sv
// Immediate-extension unit: combinational extend on the input side, then a
// registered output stage backed by a one-entry skid buffer (valid/ready both ends).
module imm_ext_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JIMM_W = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [JIMM_W-1:0] imm_i,
    input  logic [2:0]        mode_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] ext_o,
    output logic              err_o,
    output logic [1:0]        occ_o
);

    typedef enum logic [2:0] {
        M_ZERO16 = 3'd0,
        M_SIGN16 = 3'd1,
        M_LUI    = 3'd2,
        M_BRANCH = 3'd3,
        M_JUMP   = 3'd4,
        M_JABS   = 3'd5
    } mode_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    // Bits of the PC replaced by the jump index and its two zero bits.
    localparam logic [DATA_W-1:0] JLOW_MASK = (DATA_W'(1) << (JIMM_W + 2)) - DATA_W'(1);

    // Returns {err, value}.
    function automatic logic [DATA_W:0] extend(input logic [2:0]        mode,
                                               input logic [JIMM_W-1:0] imm,
                                               input logic [DATA_W-1:0] pc);
        logic signed [DATA_W-1:0] sext;
        logic        [DATA_W-1:0] jabs;
        logic        [DATA_W:0]   res;
        sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm[IMM_W-1:0]};
        jabs = DATA_W'(imm) << 2;
        res  = '0;
        case (mode)
            M_ZERO16: res[DATA_W-1:0] = {{(DATA_W-IMM_W){1'b0}}, imm[IMM_W-1:0]};
            M_SIGN16: res[DATA_W-1:0] = sext;
            M_LUI:    res[DATA_W-1:0] = {imm[IMM_W-1:0], {(DATA_W-IMM_W){1'b0}}};
            M_BRANCH: res[DATA_W-1:0] = sext <<< 2;
            M_JUMP:   res[DATA_W-1:0] = (pc & ~JLOW_MASK) | jabs;
            M_JABS:   res[DATA_W-1:0] = jabs;
            default:  res[DATA_W]     = 1'b1;
        endcase
        return res;
    endfunction

    occ_t              state_q, state_d;
    logic [DATA_W-1:0] out_q, out_d, skid_q, skid_d;
    logic              out_err_q, out_err_d, skid_err_q, skid_err_d;
    logic [DATA_W:0]   res;
    logic              accept;

    assign res         = extend(mode_i, imm_i, pc_i);
    assign in_ready_o  = (state_q != FULL);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q != EMPTY);
    assign ext_o       = out_q;
    assign err_o       = out_err_q;
    assign occ_o       = state_q;

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        out_err_d  = out_err_q;
        skid_d     = skid_q;
        skid_err_d = skid_err_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_d     = res[DATA_W-1:0];
                    out_err_d = res[DATA_W];
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (out_ready_i) begin
                    if (accept) begin
                        out_d     = res[DATA_W-1:0];
                        out_err_d = res[DATA_W];
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (accept) begin
                    // Consumer stalled: park the new result behind the held one.
                    skid_d     = res[DATA_W-1:0];
                    skid_err_d = res[DATA_W];
                    state_d    = FULL;
                end
            end
            FULL: begin
                if (out_ready_i) begin
                    out_d     = skid_q;
                    out_err_d = skid_err_q;
                    state_d   = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            out_q      <= '0;
            out_err_q  <= 1'b0;
            skid_q     <= '0;
            skid_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            out_err_q  <= out_err_d;
            skid_q     <= skid_d;
            skid_err_q <= skid_err_d;
        end
    end

endmodule
